hdb3_rx_decoder: RTL and testbench
==================================

// Module: hdb3_rx_decoder
// PURPOSE
//  Line-side HDB3 receiver: accepts 2-bit bipolar symbols, strips 000V/B00V substitutions, outputs NRZ bits.
//  Also flags line errors and loss of signal.
//  Sits downstream of the polar encoder / line model in TOP as the checked receive path.
//  Output is cycle-aligned with a valid strobe.
// PARAMETERS
//  LOS_ZEROS  32  consecutive accepted zero symbols that assert los (>=4)
//  CNT_W      16  width of saturating error counter
// PORTS
//  clk        in   1      rising-edge clock, single domain
//  rst        in   1      synchronous, active-high reset
//  hdb3_in    in   2      symbol: 2'b00 zero, 2'b01 +1, 2'b10 -1, 2'b11 illegal
//  in_valid   in   1      hdb3_in accepted on this edge when high (no back-pressure)
//  data_out   out  1      decoded NRZ bit
//  out_valid  out  1      one-cycle strobe qualifying data_out
//  cv_err     out  1      one-cycle pulse: code violation detected
//  los        out  1      level: loss of signal
//  err_cnt    out  CNT_W  saturating count of cv_err pulses
// BEHAVIOUR
//  Reset: data_out=0, out_valid=0, cv_err=0, los=0, err_cnt=0; pipe cleared; last_pol=NONE; state=FILL.
//  Input stalls (in_valid=0) freeze every register except the pulses; out_valid/cv_err drop to 0.
//  Pipe: 4-entry shift register {mark,pulse} of symbols k-3..k.
//  FSM FILL->RUN after 3 accepted symbols; RUN is terminal until rst.
//  Latency: the edge accepting symbol k+3 registers data_out for symbol k with out_valid=1.
//  No output is produced during FILL.
//  Pulse = symbol 01 or 10. V = pulse with the same polarity as last_pol.
//  The first pulse after reset is never a V. last_pol updates on every pulse, including V.
//  Valid V: entries k-1,k-2 are zeros -> V decodes 0; k-3 is forced to 0 (covers B of B00V or 0 of 000V).
//  Invalid V: k-1 or k-2 holds a pulse -> decode as mark 1, no clearing, cv_err=1.
//  Illegal symbol 2'b11: decode 0, cv_err=1, last_pol unchanged.
//  Zero run: 4th consecutive accepted zero -> cv_err=1 (HDB3 never sends 0000). Run counter saturates.
//  cv_err fires at most once per symbol even if several rules hit.
//  los: set on the edge where zero-run reaches LOS_ZEROS; cleared on the edge accepting the next pulse.
//  err_cnt increments per cv_err, saturates at 2^CNT_W-1, never wraps.
//  rst mid-stream discards pipe contents; no partial outputs are emitted.
// CONFIGURATION
//  HDB3_ERR_CNT_EN defined: err_cnt counter implemented as above.
//  HDB3_ERR_CNT_EN undefined: no counter flops; err_cnt tied to 0.
//  cv_err and los behave identically in both builds.
// STRUCTURE
//  Package hdb3_pkg: symbol encodings SYM_ZERO/SYM_POS/SYM_NEG/SYM_ILL, pol_t {NONE,POS,NEG}, FSM state enum.
//  hdb3_pkg is shared with the encoder side.
//  Sub-module hdb3_zero_mon: zero-run counter, los, 4-zero error.
//  Remaining logic (V detect, pipe, FSM, err_cnt) stays in this module.
// TESTING
//  Reset then +,0,0,0,+ (000V), then -,+ -> bits 1,0,0,0,0,1,1; cv_err never set.
//  +,-,0,0,- (B00V), then +,0,0,0 -> bits 1,0,0,0,0,1,0,0,0; cv_err never set.
//  +,0,+ (V with pulse at k-1... actually k-2) -> 3rd symbol decodes 1; cv_err pulses once; err_cnt=1.
//  Five zeros mid-stream -> cv_err on the 4th zero only.
//  LOS_ZEROS=8: 8 zeros then + -> los rises on the 8th zero and falls on the + edge.
//  Symbol 2'b11 -> data_out=0 for it, cv_err=1; in_valid gaps insert no extra out_valid.
//  rst asserted after 2 symbols -> no out_valid for 3 accepted symbols after release.
//  Build without HDB3_ERR_CNT_EN: err_cnt stays 0 under any errors.

Source files
------------

// File: rtl/hdb3_pkg.sv
// Shared HDB3 definitions: line symbol encodings, pulse polarity, receiver FSM states.
// Used by both the encoder side and the receive decoder.
// Purely declarative; no logic.
package hdb3_pkg;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_POS  = 2'b01;
    localparam logic [1:0] SYM_NEG  = 2'b10;
    localparam logic [1:0] SYM_ILL  = 2'b11;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2
    } pol_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Polarity carried by a symbol; NONE for zero and illegal symbols
    function automatic pol_t sym_pol(input logic [1:0] sym);
        if (sym == SYM_POS) return POS;
        if (sym == SYM_NEG) return NEG;
        return NONE;
    endfunction

endpackage

// File: rtl/hdb3_zero_mon.sv
// Zero-run monitor: counts consecutive accepted zero symbols, flags the 4th zero, drives los.
// Latency: four_zero is combinational on the accepting cycle; los is registered on that edge.
// No back-pressure; only accepted symbols (acc=1) advance the run.
module hdb3_zero_mon #(
    parameter int LOS_ZEROS = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic acc,
    input  logic sym_zero,
    input  logic sym_pulse,
    output logic four_zero,
    output logic los
);

    localparam int RW = $clog2(LOS_ZEROS + 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(LOS_ZEROS);
    localparam logic [RW-1:0] RUN_LAST = RW'(LOS_ZEROS - 1);
    localparam logic [RW-1:0] RUN_3    = RW'(3);

    logic [RW-1:0] run;

    // The symbol being accepted is the 4th zero in a row
    assign four_zero = acc && sym_zero && (run == RUN_3);

    // Run counter saturates at LOS_ZEROS; los sets on reaching it and clears on the next pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            run <= '0;
            los <= 1'b0;
        end else if (acc) begin
            if (sym_zero) begin
                if (run != RUN_MAX) run <= run + RW'(1);
                if (run == RUN_LAST) los <= 1'b1;
            end else begin
                run <= '0;
                if (sym_pulse) los <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hdb3_rx_decoder.sv
// HDB3 receiver: strips 000V/B00V substitutions to NRZ; flags code violations and loss of signal.
// Latency: the edge accepting symbol k+3 registers data_out for symbol k (out_valid strobe).
// No back-pressure; in_valid=0 freezes state and drops the pulses. HDB3_ERR_CNT_EN enables err_cnt.
module hdb3_rx_decoder
    import hdb3_pkg::*;
#(
    parameter int LOS_ZEROS = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       hdb3_in,
    input  logic             in_valid,
    output logic             data_out,
    output logic             out_valid,
    output logic             cv_err,
    output logic             los,
    output logic [CNT_W-1:0] err_cnt
);

    // Window history: index 0 = k-1, 1 = k-2, 2 = k-3 relative to the incoming symbol k
    logic [2:0] pipe_mark;
    logic [2:0] pipe_pulse;
    state_t     state;
    logic [1:0] fill_cnt;
    pol_t       last_pol;

    logic is_zero, is_pulse, is_ill;
    pol_t in_pol;
    logic is_v, v_ok, v_bad, new_mark, out_bit, four_zero, cv_next;

    // Classify the incoming symbol and resolve V / substitution decisions
    always_comb begin
        is_zero  = (hdb3_in == SYM_ZERO);
        is_ill   = (hdb3_in == SYM_ILL);
        is_pulse = !is_zero && !is_ill;
        in_pol   = sym_pol(hdb3_in);
        is_v     = is_pulse && (in_pol == last_pol);
        v_ok     = is_v && !pipe_pulse[0] && !pipe_pulse[1];
        v_bad    = is_v && !v_ok;
        new_mark = is_pulse && !v_ok;
        // A valid V also retires k-3 as a zero (B of B00V or leading 0 of 000V)
        out_bit  = pipe_mark[2] && !v_ok;
        cv_next  = v_bad || is_ill || four_zero;
    end

    hdb3_zero_mon #(
        .LOS_ZEROS(LOS_ZEROS)
    ) u_zero_mon (
        .clk       (clk),
        .rst       (rst),
        .acc       (in_valid),
        .sym_zero  (is_zero),
        .sym_pulse (is_pulse),
        .four_zero (four_zero),
        .los       (los)
    );

    // Pipe shift, polarity tracking, FILL/RUN sequencing and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_mark  <= '0;
            pipe_pulse <= '0;
            state      <= FILL;
            fill_cnt   <= '0;
            last_pol   <= NONE;
            data_out   <= 1'b0;
            out_valid  <= 1'b0;
            cv_err     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            cv_err    <= 1'b0;
            if (in_valid) begin
                pipe_mark  <= {pipe_mark[1:0], new_mark};
                pipe_pulse <= {pipe_pulse[1:0], is_pulse};
                if (is_pulse) last_pol <= in_pol;
                cv_err <= cv_next;
                case (state)
                    FILL: begin
                        fill_cnt <= fill_cnt + 2'd1;
                        if (fill_cnt == 2'd2) state <= RUN;
                    end
                    RUN: begin
                        data_out  <= out_bit;
                        out_valid <= 1'b1;
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

`ifdef HDB3_ERR_CNT_EN
    // Saturating count of code violations
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (in_valid && cv_next && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_hdb3_rx_decoder.sv
// Self-checking bench for hdb3_rx_decoder: directed HDB3 sequences plus randomized symbol streams.
// A symbol-history model predicts every output after each clock edge.
// Honours HDB3_ERR_CNT_EN for the expected error count.
module tb_hdb3_rx_decoder;

    localparam int LOS_ZEROS = 8;
    localparam int CNT_W     = 4;
    localparam logic [1:0] Z = 2'b00;
    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] N = 2'b10;
    localparam logic [1:0] I = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       hdb3_in = 2'b00;
    logic             in_valid = 1'b0;
    logic             data_out, out_valid, cv_err, los;
    logic [CNT_W-1:0] err_cnt;

    hdb3_rx_decoder #(.LOS_ZEROS(LOS_ZEROS), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .hdb3_in   (hdb3_in),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .out_valid (out_valid),
        .cv_err    (cv_err),
        .los       (los),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: full history of accepted symbols since the last reset
    int   m_n;
    int   m_dec[$];
    bit   m_pulse[$];
    int   m_zrun;
    int   m_lastp;   // 0 none, 1 positive, 2 negative
    logic exp_vld, exp_dat, exp_cv, exp_los;
    int   exp_cnt;

    // Observation for directed literal checks
    bit   obs_bits[$];
    bit   los_hist[$];
    int   cv_cnt;
    int   cv_at;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_dec.delete();
        m_pulse.delete();
        m_zrun = 0;
        m_lastp = 0;
        exp_vld = 0; exp_dat = 0; exp_cv = 0; exp_los = 0; exp_cnt = 0;
    endtask

    task automatic model_accept(input logic [1:0] s);
        bit pulse, isv, near, bad;
        int p, d;
        pulse = (s == P) || (s == N);
        p     = (s == P) ? 1 : 2;
        isv   = pulse && (m_lastp == p);
        near  = (m_n >= 1 && m_pulse[m_n-1]) || (m_n >= 2 && m_pulse[m_n-2]);
        d     = pulse ? 1 : 0;
        bad   = 0;
        if (isv && !near) begin
            d = 0;
            if (m_n >= 3) m_dec[m_n-3] = 0;
        end
        if (isv && near) bad = 1;
        if (pulse) m_lastp = p;
        if (s == Z) m_zrun++; else m_zrun = 0;
        if (m_zrun == 4) bad = 1;
        if (s == I) bad = 1;
        if (m_zrun == LOS_ZEROS) exp_los = 1;
        if (pulse) exp_los = 0;
        m_dec.push_back(d);
        m_pulse.push_back(pulse);
        if (m_n >= 3) begin
            exp_vld = 1;
            exp_dat = m_dec[m_n-3][0];
        end
        m_n++;
        exp_cv = bad;
`ifdef HDB3_ERR_CNT_EN
        if (bad && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`endif
    endtask

    // One clock: drive, let the edge happen, update model, compare every output
    task automatic step(input logic v, input logic [1:0] s, input logic r);
        rst = r; in_valid = v; hdb3_in = s;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else begin
            exp_vld = 0;
            exp_cv  = 0;
            if (v) model_accept(s);
        end
        chk("out_valid", out_valid, exp_vld);
        chk("data_out",  data_out,  exp_dat);
        chk("cv_err",    cv_err,    exp_cv);
        chk("los",       los,       exp_los);
        chk("err_cnt",   err_cnt,   exp_cnt);
        if (out_valid) obs_bits.push_back(data_out);
        if (cv_err) begin
            cv_cnt++;
            cv_at = m_n - 1;
        end
        if (v && !r) los_hist.push_back(los);
    endtask

    task automatic send(input logic [1:0] s);
        step(1'b1, s, 1'b0);
    endtask

    task automatic stall();
        step(1'b0, Z, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, Z, 1'b1);
        obs_bits.delete();
        los_hist.delete();
        cv_cnt = 0;
        cv_at  = -1;
    endtask

    function automatic int packed_bits(input int k);
        int v = 0;
        for (int i = 0; i < k; i++)
            v = (v << 1) | ((i < obs_bits.size()) ? int'(obs_bits[i]) : 0);
        return v;
    endfunction

    initial begin
        model_reset();
        cv_cnt = 0;
        cv_at  = -1;

        // 000V then -,+ ; padding -,+,- flushes the pipe
        do_reset();
        send(P); send(Z); send(Z); send(Z); send(P); send(N); send(P);
        send(N); send(P); send(N);
        chk("d1_count", obs_bits.size(), 7);
        chk("d1_bits",  packed_bits(7), 'b1000011);
        chk("d1_cv",    cv_cnt, 0);

        // B00V then +,0,0,0
        do_reset();
        send(P); send(N); send(Z); send(Z); send(N); send(P); send(Z); send(Z); send(Z);
        send(N); send(P); send(N);
        chk("d2_count", obs_bits.size(), 9);
        chk("d2_bits",  packed_bits(9), 'b100001000);
        chk("d2_cv",    cv_cnt, 0);

        // Invalid V with a pulse two symbols back
        do_reset();
        send(P); send(Z); send(P);
        chk("d3_cv_early", cv_cnt, 1);
        send(N); send(P); send(N);
        chk("d3_bits",  packed_bits(3), 'b101);
        chk("d3_cv",    cv_cnt, 1);
`ifdef HDB3_ERR_CNT_EN
        chk("d3_errcnt", err_cnt, 1);
`else
        chk("d3_errcnt", err_cnt, 0);
`endif

        // Five zeros mid-stream: only the 4th zero (index 5) is a violation
        do_reset();
        send(P); send(N); send(Z); send(Z); send(Z); send(Z); send(Z); send(P);
        chk("d4_cv_cnt", cv_cnt, 1);
        chk("d4_cv_at",  cv_at, 5);

        // los rises on the 8th zero, falls on the following pulse
        do_reset();
        send(P);
        for (int i = 0; i < 8; i++) send(Z);
        send(P);
        chk("d5_los_7", los_hist[7], 0);
        chk("d5_los_8", los_hist[8], 1);
        chk("d5_los_9", los_hist[9], 0);

        // Illegal symbol with input gaps
        do_reset();
        send(P); stall(); send(N); stall(); stall(); send(I); send(P); stall();
        send(N); send(P); send(N);
        chk("d6_count", obs_bits.size(), 4);
        chk("d6_bits",  packed_bits(4), 'b1101);
        chk("d6_cv",    cv_cnt, 1);

        // Reset mid-stream restarts the fill
        do_reset();
        send(P); send(N);
        do_reset();
        send(P); send(N); send(P);
        chk("d7_nofill", obs_bits.size(), 0);
        send(N);
        chk("d7_first", obs_bits.size(), 1);

        // Randomized streams: mixed symbols, stalls, occasional resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int r, zw;
            logic [1:0] s;
            zw = (i >= 2000 && i < 3000) ? 75 : 40;
            r  = $urandom_range(99);
            if (r < zw) s = Z;
            else if (r < zw + (96 - zw) / 2) s = P;
            else if (r < 96) s = N;
            else s = I;
            if ($urandom_range(999) < 4) step(1'b0, Z, 1'b1);
            else step($urandom_range(99) < 85, s, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
